matched_fir: RTL

MATCHED_FIR -- requirements
Module: matched_fir

---
 rtl/matched_fir_pkg.sv | 46 ++++
 rtl/fir_delay_line.sv | 58 +++++
 rtl/matched_fir.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/matched_fir_pkg.sv
// -----------------------------------------------------------------------------
// matched_fir_pkg
// Shared definitions for the matched FIR filter: FSM state type, the constant
// coefficient table and the accumulator-width helper.
//
// The coefficient table is a 16-tap symmetric pulse-shaping matched filter.
// For builds with more taps the table repeats (coef_at wraps the index).
//
// Configuration macro used by the filter: MATCHED_FIR_SAT_EN
//   (see matched_fir.sv for its effect).
// -----------------------------------------------------------------------------
package matched_fir_pkg;

  localparam int MF_DW    = 16;
  localparam int MF_NTAPS = 16;
  localparam int MF_CW    = $clog2(MF_NTAPS);

  // Width that holds NTAPS full-scale products without overflow.
  function automatic int acc_width(input int dw, input int ntaps);
    return 2 * dw + $clog2(ntaps);
  endfunction

  localparam int MF_ACC_W = acc_width(MF_DW, MF_NTAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam logic signed [MF_DW-1:0] MF_COEF [MF_NTAPS] = '{
    16'sd1200,  -16'sd800,  16'sd2400,  16'sd4100,
    16'sd6200,  16'sd8300,  16'sd9800,  16'sd10400,
    16'sd10400, 16'sd9800,  16'sd8300,  16'sd6200,
    16'sd4100,  16'sd2400,  -16'sd800,  16'sd1200
  };

  // Tap index k (0..63) to coefficient; table length is a power of two,
  // so the modulo is a plain truncation in hardware.
  function automatic logic signed [MF_DW-1:0] coef_at(input logic [5:0] k);
    logic [MF_CW-1:0] idx;
    idx = MF_CW'(k % 6'(MF_NTAPS));
    return MF_COEF[idx];
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// -----------------------------------------------------------------------------
// fir_delay_line
// Circular sample history for the matched FIR. A write stores the sample at
// the write pointer and advances it (wrapping at NTAPS). The read port returns
// x[n-k] for tap offset k, where x[n] is the most recently written sample.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset; clears pointer and history
//   wr_en_i    write the sample this cycle
//   wr_data_i  sample to write
//   tap_i      tap offset k (0 = newest sample)
//   rd_data_o  x[n-k], combinational
// -----------------------------------------------------------------------------
module fir_delay_line #(
  parameter int NTAPS = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [$clog2(NTAPS)-1:0] tap_i,
  output logic [DW-1:0]            rd_data_o
);

  localparam int PW = $clog2(NTAPS);

  logic [DW-1:0] mem_q [NTAPS];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_addr_s;

  // Pointer advance; NTAPS is a power of two so the wrap is free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(1);
  end

  // Newest sample sits one slot behind the write pointer.
  always_comb begin
    rd_addr_s = wr_ptr_q - PW'(1) - tap_i;
    rd_data_o = mem_q[rd_addr_s];
  end

  // History storage and write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q        <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/matched_fir.sv
// -----------------------------------------------------------------------------
// matched_fir
// Single-MAC matched FIR filter. Each accepted sample triggers NTAPS
// multiply-accumulate cycles followed by one emit cycle, so one sample is
// processed every NTAPS+2 cycles and out_valid rises NTAPS+1 cycles after
// acceptance.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset; aborts any computation
//   in_valid   input sample present
//   in         signed input sample
//   in_ready   block can accept a sample (IDLE only)
//   out        signed filtered sample, registered, held between updates
//   out_valid  one-cycle pulse when out is updated
//
// Configuration:
//   MATCHED_FIR_SAT_EN  defined   -> shifted result clamps to the DW-bit range
//                       undefined -> low DW bits of the shifted result (wrap)
// -----------------------------------------------------------------------------
module matched_fir
  import matched_fir_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int SHIFT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in,
  output logic          in_ready,
  output logic [DW-1:0] out,
  output logic          out_valid
);

  localparam int TW    = $clog2(NTAPS);
  localparam int ACC_W = acc_width(DW, NTAPS);

  state_e                    state_q, state_d;
  logic [TW-1:0]             tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DW-1:0]             out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic                      accept_s;
  logic                      last_tap_s;
  logic [DW-1:0]             rd_data_s;
  logic signed [DW-1:0]      coef_s;
  logic signed [DW-1:0]      x_s;
  logic signed [2*DW-1:0]    prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic [DW-1:0]             reduced_s;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (accept_s),
    .wr_data_i (in),
    .tap_i     (tap_q),
    .rd_data_o (rd_data_s)
  );

  assign accept_s   = in_valid & in_ready_q;
  assign last_tap_s = (tap_q == TW'(NTAPS - 1));

  // One product per MAC cycle; sum_s is the accumulator after this product.
  always_comb begin
    coef_s = DW'(coef_at(6'(tap_q)));
    x_s    = signed'(rd_data_s);
    prod_s = (2*DW)'(coef_s) * (2*DW)'(x_s);
    sum_s  = acc_q + ACC_W'(prod_s);
  end

`ifdef MATCHED_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted_s;

  // Shift, then clamp to the representable output range.
  always_comb begin
    shifted_s = sum_s >>> SHIFT;
    if (shifted_s > SAT_MAX) begin
      reduced_s = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      reduced_s = {1'b1, {(DW-1){1'b0}}};
    end else begin
      reduced_s = DW'(shifted_s);
    end
  end
`else
  // Shift, then keep the low DW bits (two's complement wrap).
  always_comb begin
    reduced_s = DW'(sum_s >>> SHIFT);
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (last_tap_s) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_EMIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so they register in step with it.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_EMIT);
  end

  // Datapath next-state: accumulator, tap counter and output sample.
  always_comb begin
    tap_d = tap_q;
    acc_d = acc_q;
    out_d = out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          tap_d = '0;
          acc_d = '0;
        end else begin
          tap_d = tap_q;
          acc_d = acc_q;
        end
      end
      ST_MAC: begin
        acc_d = sum_s;
        tap_d = tap_q + TW'(1);
        // Output is loaded on the last MAC edge so it is visible in EMIT.
        if (last_tap_s) begin
          out_d = reduced_s;
        end else begin
          out_d = out_q;
        end
      end
      ST_EMIT: begin
        out_d = out_q;
      end
      default: begin
        tap_d = '0;
        acc_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
